// File: rtl/vm_change_dispenser.sv
// ---------------------------------------------------------------------------
// vm_change_dispenser
//
// Change-dispensing engine for the vending machine datapath. It keeps a coin
// inventory for each denomination. Inserted coins add to that inventory. A
// change request is handled in two phases:
//   PLAN     - one greedy step per cycle, walking codes from largest value
//              (code 0) to smallest.
//   DISPENSE - the planned coins are handed out one per valid/ready
//              handshake.
// If the amount cannot be paid, no_change pulses and the inventory is left
// untouched.
//
// Ports
//   clk                       rising-edge clock
//   rst                       asynchronous reset, active low
//   money / money_valid       inserted coin code, 1-cycle strobe
//   refill                    1-cycle strobe: reload all counts (IDLE only)
//   change_req/change_amount  1-cycle strobe starting a payout of the amount
//   change_ready              downstream accepts the presented coin
//   busy                      request in progress (PLAN or DISPENSE)
//   change_denomination_code  code of the presented coin
//   change_valid              a coin is presented
//   no_change                 1-cycle pulse: the amount cannot be paid
//   done                      1-cycle pulse: payout complete
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module vm_change_dispenser #(
    parameter int                         NUM_DENOM    = 4,
    parameter int                         CODE_W       = 4,
    parameter int                         AMT_W        = 8,
    parameter int                         CNT_W        = 6,
    parameter int                         INIT_COUNT   = 8,
    parameter logic [NUM_DENOM*AMT_W-1:0] DENOM_VALUES = {8'd1, 8'd2, 8'd5, 8'd10}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CODE_W-1:0] money,
    input  logic              money_valid,
    input  logic              refill,
    input  logic              change_req,
    input  logic [AMT_W-1:0]  change_amount,
    input  logic              change_ready,
    output logic              busy,
    output logic [CODE_W-1:0] change_denomination_code,
    output logic              change_valid,
    output logic              no_change,
    output logic              done
);

    localparam int               IDX_W    = (NUM_DENOM > 1) ? $clog2(NUM_DENOM) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DENOM - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(INIT_COUNT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLAN,
        S_DISPENSE
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [AMT_W-1:0]   rem_q, rem_d;
    logic [CNT_W-1:0]   plan_q  [NUM_DENOM];
    logic [CNT_W-1:0]   plan_d  [NUM_DENOM];
    logic [CNT_W-1:0]   count_q [NUM_DENOM];
    logic [CNT_W-1:0]   count_d [NUM_DENOM];
    logic               busy_q, busy_d;
    logic               valid_q, valid_d;
    logic [CODE_W-1:0]  code_q, code_d;
    logic               no_change_q, no_change_d;
    logic               done_q, done_d;

    // Per-code decode of this cycle's events and the plan left after any
    // accept, used to choose the next coin to present.
    logic [NUM_DENOM-1:0] accept_sel;
    logic [NUM_DENOM-1:0] insert_sel;
    logic [CNT_W-1:0]     plan_after [NUM_DENOM];
    logic                 pend_any;
    logic [CODE_W-1:0]    pend_code;
    logic [AMT_W-1:0]     cur_val;
    logic [CNT_W-1:0]     cur_plan;
    logic [CNT_W-1:0]     cur_count;

    always_comb begin : decode
        // NOTE: every variable driven here gets a default first, so no path
        // can leave one unassigned and infer a latch.
        accept_sel = '0;
        insert_sel = '0;
        pend_any   = 1'b0;
        pend_code  = '0;
        cur_val    = '0;
        cur_plan   = '0;
        cur_count  = '0;
        for (int i = 0; i < NUM_DENOM; i++) begin
            accept_sel[i] = valid_q && change_ready && (code_q == CODE_W'(i));
            insert_sel[i] = money_valid && (money == CODE_W'(i));
            plan_after[i] = plan_q[i] - CNT_W'(accept_sel[i]);
            if (idx_q == IDX_W'(i)) begin
                cur_val   = DENOM_VALUES[i*AMT_W +: AMT_W];
                cur_plan  = plan_q[i];
                cur_count = count_q[i];
            end
        end
        // Walk downwards so the lowest pending code wins.
        for (int i = NUM_DENOM - 1; i >= 0; i--) begin
            if (plan_after[i] != '0) begin
                pend_any  = 1'b1;
                pend_code = CODE_W'(i);
            end
        end
    end

    always_comb begin : next_state
        state_d     = state_q;
        idx_d       = idx_q;
        rem_d       = rem_q;
        plan_d      = plan_q;
        busy_d      = busy_q;
        valid_d     = valid_q;
        code_d      = code_q;
        no_change_d = 1'b0;
        done_d      = 1'b0;

        // Inventory: refill has priority and only applies when idle. An insert
        // and an accept of the same code in one cycle cancel out.
        for (int i = 0; i < NUM_DENOM; i++) begin
            count_d[i] = count_q[i];
            if (state_q == S_IDLE && refill) begin
                count_d[i] = CNT_INIT;
            end else if (accept_sel[i] && !insert_sel[i]) begin
                count_d[i] = count_q[i] - CNT_W'(1);
            end else if (insert_sel[i] && !accept_sel[i] && count_q[i] != CNT_MAX) begin
                count_d[i] = count_q[i] + CNT_W'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (change_req) begin
                    rem_d   = change_amount;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_PLAN;
                    for (int i = 0; i < NUM_DENOM; i++) plan_d[i] = '0;
                end
            end

            S_PLAN: begin
                if (rem_q == '0) begin
                    if (pend_any) begin
                        valid_d = 1'b1;
                        code_d  = pend_code;
                        state_d = S_DISPENSE;
                    end else begin
                        // Zero amount: finish without presenting any coin.
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end
                end else if (rem_q >= cur_val && cur_plan < cur_count) begin
                    // Planning against count keeps plan <= count, so the
                    // dispense phase never underflows the inventory.
                    for (int i = 0; i < NUM_DENOM; i++) begin
                        if (idx_q == IDX_W'(i)) plan_d[i] = plan_q[i] + CNT_W'(1);
                    end
                    rem_d = rem_q - cur_val;
                end else if (idx_q == IDX_LAST) begin
                    // Greedy walk exhausted: abandon the plan, inventory intact.
                    no_change_d = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = S_IDLE;
                    for (int i = 0; i < NUM_DENOM; i++) plan_d[i] = '0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end

            S_DISPENSE: begin
                // Without an accept the presented coin is simply held.
                if (valid_q && change_ready) begin
                    plan_d = plan_after;
                    if (pend_any) begin
                        code_d = pend_code;
                    end else begin
                        valid_d = 1'b0;
                        code_d  = '0;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    // NOTE: the count/plan arrays are only NUM_DENOM registers each and the
    // inventory must reload on reset, so they are reset like ordinary flops
    // rather than treated as an unreset memory.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            rem_q       <= '0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            code_q      <= '0;
            no_change_q <= 1'b0;
            done_q      <= 1'b0;
            for (int i = 0; i < NUM_DENOM; i++) begin
                plan_q[i]  <= '0;
                count_q[i] <= CNT_INIT;
            end
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop
            // samples the same pre-edge values regardless of statement order.
            state_q     <= state_d;
            idx_q       <= idx_d;
            rem_q       <= rem_d;
            busy_q      <= busy_d;
            valid_q     <= valid_d;
            code_q      <= code_d;
            no_change_q <= no_change_d;
            done_q      <= done_d;
            plan_q      <= plan_d;
            count_q     <= count_d;
        end
    end

    assign busy                     = busy_q;
    assign change_valid             = valid_q;
    assign change_denomination_code = code_q;
    assign no_change                = no_change_q;
    assign done                     = done_q;

endmodule

// File: tb/tb_vm_change_dispenser.sv
// ---------------------------------------------------------------------------
// tb_vm_change_dispenser
//
// Directed bench for vm_change_dispenser with the default parameters
// (values: code0=10, code1=5, code2=2, code3=1; 8 coins each after reset).
// Inputs change 1 time unit after the rising edge; outputs are sampled at
// the same point, well away from the edge.
// ---------------------------------------------------------------------------
module tb_vm_change_dispenser;

    logic       clk;
    logic       rst;
    logic [3:0] money;
    logic       money_valid;
    logic       refill;
    logic       change_req;
    logic [7:0] change_amount;
    logic       change_ready;
    logic       busy;
    logic [3:0] change_denomination_code;
    logic       change_valid;
    logic       no_change;
    logic       done;

    int checks;
    int errors;

    int coin_q[$];
    bit saw_done;
    bit saw_nc;
    bit saw_valid;
    bit hold_ok;

    vm_change_dispenser dut (
        .clk                      (clk),
        .rst                      (rst),
        .money                    (money),
        .money_valid              (money_valid),
        .refill                   (refill),
        .change_req               (change_req),
        .change_amount            (change_amount),
        .change_ready             (change_ready),
        .busy                     (busy),
        .change_denomination_code (change_denomination_code),
        .change_valid             (change_valid),
        .no_change                (no_change),
        .done                     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_counts(input string tag, input int c0, input int c1,
                                input int c2, input int c3);
        check({tag, "_cnt0"}, int'(dut.count_q[0]), c0);
        check({tag, "_cnt1"}, int'(dut.count_q[1]), c1);
        check({tag, "_cnt2"}, int'(dut.count_q[2]), c2);
        check({tag, "_cnt3"}, int'(dut.count_q[3]), c3);
    endtask

    task automatic do_refill();
        refill = 1'b1;
        tick();
        refill = 1'b0;
    endtask

    // Issue a request and follow it to done/no_change. The first `stall`
    // cycles with a coin presented are held off with change_ready=0, and the
    // presented code must stay put during them.
    task automatic payout(input logic [7:0] amt, input int stall);
        int         cycles;
        int         stalls_left;
        logic [3:0] held;
        coin_q.delete();
        saw_done    = 1'b0;
        saw_nc      = 1'b0;
        saw_valid   = 1'b0;
        hold_ok     = 1'b1;
        held        = '0;
        stalls_left = stall;
        change_ready  = (stall == 0);
        change_amount = amt;
        change_req    = 1'b1;
        tick();
        change_req = 1'b0;
        cycles = 0;
        while (!saw_done && !saw_nc && cycles < 300) begin
            if (done)      saw_done = 1'b1;
            if (no_change) saw_nc   = 1'b1;
            if (change_valid) begin
                saw_valid = 1'b1;
                if (stalls_left > 0) begin
                    if (stalls_left == stall) held = change_denomination_code;
                    else if (change_denomination_code !== held) hold_ok = 1'b0;
                    stalls_left--;
                end else begin
                    change_ready = 1'b1;
                    coin_q.push_back(int'(change_denomination_code));
                end
            end else if (saw_valid && stalls_left > 0) begin
                hold_ok = 1'b0;
            end
            if (!saw_done && !saw_nc) begin
                tick();
                cycles++;
            end
        end
        check("payout_timeout", int'(cycles < 300), 1);
        change_ready = 1'b0;
    endtask

    initial begin
        int cycles;
        checks        = 0;
        errors        = 0;
        rst           = 1'b0;
        money         = '0;
        money_valid   = 1'b0;
        refill        = 1'b0;
        change_req    = 1'b0;
        change_amount = '0;
        change_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;

        // ---- reset state ----
        check("rst_busy",  busy, 0);
        check("rst_valid", change_valid, 0);
        check("rst_code",  change_denomination_code, 0);
        check("rst_nc",    no_change, 0);
        check("rst_done",  done, 0);
        check_counts("rst", 8, 8, 8, 8);

        // ---- 1: amount 17 -> 10 + 5 + 2 ----
        change_ready  = 1'b1;
        change_amount = 8'd17;
        change_req    = 1'b1;
        tick();
        change_req = 1'b0;
        check("t1_busy_next", busy, 1);
        check("t1_valid_plan", change_valid, 0);
        coin_q.delete();
        saw_done = 1'b0;
        cycles   = 0;
        while (!saw_done && cycles < 100) begin
            if (done) saw_done = 1'b1;
            else begin
                if (change_valid) coin_q.push_back(int'(change_denomination_code));
                tick();
                cycles++;
            end
        end
        check("t1_done",   saw_done, 1);
        check("t1_ncoins", coin_q.size(), 3);
        if (coin_q.size() == 3) begin
            check("t1_coin0", coin_q[0], 0);
            check("t1_coin1", coin_q[1], 1);
            check("t1_coin2", coin_q[2], 2);
        end
        check("t1_valid_at_done", change_valid, 0);
        check("t1_busy_at_done",  busy, 0);
        tick();
        check("t1_done_pulse", done, 0);
        check_counts("t1", 7, 7, 7, 8);
        change_ready = 1'b0;

        // ---- 2: amount 10 with 3 stalled cycles ----
        payout(8'd10, 3);
        check("t2_hold",   hold_ok, 1);
        check("t2_done",   saw_done, 1);
        check("t2_ncoins", coin_q.size(), 1);
        if (coin_q.size() == 1) check("t2_coin0", coin_q[0], 0);
        check_counts("t2", 6, 7, 7, 8);

        // ---- refill, and refill wins over a simultaneous insert ----
        money       = 4'd1;
        money_valid = 1'b1;
        do_refill();
        money_valid = 1'b0;
        check_counts("refill", 8, 8, 8, 8);

        // ---- 3: drain, then an unpayable 40 ----
        payout(8'd80, 0);
        check("t3a_done",   saw_done, 1);
        check("t3a_ncoins", coin_q.size(), 8);
        payout(8'd56, 0);
        check("t3b_done",   saw_done, 1);
        check("t3b_ncoins", coin_q.size(), 16);
        check_counts("t3b", 0, 0, 0, 8);
        payout(8'd40, 0);
        check("t3c_nc",    saw_nc, 1);
        check("t3c_done",  saw_done, 0);
        check("t3c_valid", saw_valid, 0);
        check("t3c_busy",  busy, 0);
        tick();
        check("t3c_nc_pulse", no_change, 0);
        check_counts("t3c", 0, 0, 0, 8);

        // ---- 4: zero amount ----
        change_amount = 8'd0;
        change_req    = 1'b1;
        tick();
        change_req = 1'b0;
        check("t4_busy",  busy, 1);
        check("t4_done0", done, 0);
        tick();
        check("t4_done",  done, 1);
        check("t4_busy1", busy, 0);
        check("t4_valid", change_valid, 0);
        tick();
        check("t4_done_pulse", done, 0);

        // ---- 5: insert during accept of the same code, bad code, saturation ----
        do_refill();
        change_amount = 8'd10;
        change_req    = 1'b1;
        tick();
        change_req = 1'b0;
        cycles = 0;
        while (!change_valid && cycles < 50) begin
            tick();
            cycles++;
        end
        check("t5_valid", change_valid, 1);
        check("t5_code",  change_denomination_code, 0);
        change_ready = 1'b1;
        money        = 4'd0;
        money_valid  = 1'b1;
        tick();
        money_valid  = 1'b0;
        change_ready = 1'b0;
        check("t5_done", done, 1);
        check_counts("t5a", 8, 8, 8, 8);
        money       = 4'd7;
        money_valid = 1'b1;
        tick();
        money_valid = 1'b0;
        check_counts("t5b", 8, 8, 8, 8);
        money       = 4'd3;
        money_valid = 1'b1;
        repeat (60) tick();
        money_valid = 1'b0;
        check_counts("t5c", 8, 8, 8, 63);

        // ---- 6: reset during DISPENSE ----
        do_refill();
        check_counts("t6_refill", 8, 8, 8, 8);
        change_amount = 8'd17;
        change_req    = 1'b1;
        tick();
        change_req = 1'b0;
        cycles = 0;
        while (!change_valid && cycles < 50) begin
            tick();
            cycles++;
        end
        check("t6_valid", change_valid, 1);
        change_ready = 1'b1;
        tick();
        change_ready = 1'b0;
        check("t6_code1", change_denomination_code, 1);
        check("t6_cnt0_dec", int'(dut.count_q[0]), 7);
        #2;
        rst = 1'b0;
        #1;
        check("t6_rst_valid", change_valid, 0);
        check("t6_rst_busy",  busy, 0);
        check("t6_rst_code",  change_denomination_code, 0);
        check("t6_rst_done",  done, 0);
        check("t6_rst_nc",    no_change, 0);
        check_counts("t6_rst", 8, 8, 8, 8);
        tick();
        rst = 1'b1;
        payout(8'd17, 0);
        check("t6_done",   saw_done, 1);
        check("t6_ncoins", coin_q.size(), 3);
        if (coin_q.size() == 3) begin
            check("t6_coin0", coin_q[0], 0);
            check("t6_coin1", coin_q[1], 1);
            check("t6_coin2", coin_q[2], 2);
        end
        check_counts("t6_end", 7, 7, 7, 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
